// File: rtl/dram_bist_pkg.sv
// Shared types and the expected-bit helper for the dram_bist_ctrl march-test sequencer.
package dram_bist_pkg;

  localparam int MAX_ADDR_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR     = 3'd1,
    ST_RD     = 3'd2,
    ST_WR_INV = 3'd3,
    ST_RD_INV = 3'd4,
    ST_DONE   = 3'd5
  } bist_state_e;

  typedef enum logic [1:0] {
    PAT_ZERO   = 2'd0,
    PAT_ONE    = 2'd1,
    PAT_CHECK  = 2'd2,
    PAT_PARITY = 2'd3
  } pat_sel_e;

  // Callers zero-extend the address, which leaves addr[0] and the parity unchanged.
  function automatic logic exp_bit(input pat_sel_e sel,
                                   input logic [MAX_ADDR_W-1:0] addr,
                                   input logic inv);
    logic b;
    case (sel)
      PAT_ZERO:   b = 1'b0;
      PAT_ONE:    b = 1'b1;
      PAT_CHECK:  b = addr[0];
      PAT_PARITY: b = ^addr;
      default:    b = 1'b0;
    endcase
    return b ^ inv;
  endfunction

endpackage

// File: rtl/dram_bist_addr_cnt.sv
// March address counter: synchronous clear, count enable and a flag at the last address.
module dram_bist_addr_cnt #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_tc
);

  logic [ADDR_W-1:0] r_addr;

  // Address register; clear has priority and the increment wraps naturally at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= {ADDR_W{1'b0}};
    end else if (i_clr) begin
      r_addr <= {ADDR_W{1'b0}};
    end else if (i_en) begin
      r_addr <= r_addr + ADDR_W'(1);
    end else begin
      r_addr <= r_addr;
    end
  end

  assign o_addr = r_addr;
  assign o_tc   = (r_addr == {ADDR_W{1'b1}});

endmodule

// File: rtl/dram_bist_ctrl.sv
// Four-phase march-test sequencer for a 256x1 dual-port distributed RAM.
// Optional build macro DRAM_BIST_SPO_CHECK_EN also compares the SPO read port.
module dram_bist_ctrl
  import dram_bist_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        pattern_sel,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_d,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_dpra,
  input  logic              ram_spo,
  input  logic              ram_dpo,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] err_addr,
  output logic [ERR_W-1:0]  err_count
);

  bist_state_e           r_state;
  bist_state_e           w_state_nxt;
  pat_sel_e              r_pat;
  logic                  r_start_s;
  logic                  r_start_d;
  logic                  w_start_edge;
  logic                  w_launch;
  logic                  w_cnt_clr;
  logic                  w_cnt_en;
  logic [ADDR_W-1:0]     w_addr;
  logic [MAX_ADDR_W-1:0] w_addr_ext;
  logic                  w_tc;
  logic                  w_inv;
  logic                  w_wr_phase;
  logic                  w_rd_phase;
  logic                  w_last_cmp;
  logic                  w_exp;
  logic                  w_dpo_mis;
  logic                  w_spo_mis;
  logic                  w_mis;
  logic [ERR_W-1:0]      r_err_count;
  logic [ERR_W-1:0]      w_err_nxt;
  logic [ADDR_W-1:0]     r_err_addr;
  logic                  r_pass;
  logic                  r_busy;
  logic                  r_done;

  dram_bist_addr_cnt #(.ADDR_W(ADDR_W)) u_addr_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_cnt_clr),
    .i_en   (w_cnt_en),
    .o_addr (w_addr),
    .o_tc   (w_tc)
  );

  // Two-stage start capture; the edge is seen one cycle after start is first sampled high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_s <= 1'b0;
      r_start_d <= 1'b0;
    end else begin
      r_start_s <= start;
      r_start_d <= r_start_s;
    end
  end

  assign w_start_edge = r_start_s & ~r_start_d;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and counter control; every phase advances one address per cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;
    w_launch    = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_start_edge) begin
          w_state_nxt = ST_WR;
          w_cnt_clr   = 1'b1;
          w_launch    = 1'b1;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_WR: begin
        w_cnt_en = 1'b1;
        if (w_tc) w_state_nxt = ST_RD;
        else      w_state_nxt = ST_WR;
      end
      ST_RD: begin
        w_cnt_en = 1'b1;
        if (w_tc) w_state_nxt = ST_WR_INV;
        else      w_state_nxt = ST_RD;
      end
      ST_WR_INV: begin
        w_cnt_en = 1'b1;
        if (w_tc) w_state_nxt = ST_RD_INV;
        else      w_state_nxt = ST_WR_INV;
      end
      ST_RD_INV: begin
        w_cnt_en = 1'b1;
        if (w_tc) w_state_nxt = ST_DONE;
        else      w_state_nxt = ST_RD_INV;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_wr_phase = (r_state == ST_WR) | (r_state == ST_WR_INV);
  assign w_rd_phase = (r_state == ST_RD) | (r_state == ST_RD_INV);
  assign w_inv      = (r_state == ST_WR_INV) | (r_state == ST_RD_INV);
  assign w_last_cmp = (r_state == ST_RD_INV) & w_tc;
  assign w_addr_ext = MAX_ADDR_W'(w_addr);
  assign w_exp      = exp_bit(r_pat, w_addr_ext, w_inv);
  assign w_dpo_mis  = (ram_dpo != w_exp);

`ifdef DRAM_BIST_SPO_CHECK_EN
  assign w_spo_mis = (ram_spo != w_exp);
`else
  // SPO is not compared in this build; the term is held at zero.
  assign w_spo_mis = ram_spo & 1'b0;
`endif

  assign w_mis = w_rd_phase & (w_dpo_mis | w_spo_mis);

  // Saturating count; a mismatch on both ports in one cycle is still one error.
  always_comb begin
    w_err_nxt = r_err_count;
    if (w_launch) begin
      w_err_nxt = {ERR_W{1'b0}};
    end else if (w_mis && (r_err_count != {ERR_W{1'b1}})) begin
      w_err_nxt = r_err_count + ERR_W'(1);
    end else begin
      w_err_nxt = r_err_count;
    end
  end

  // Result registers; pass is resolved on DONE entry so it includes the final compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat       <= PAT_ZERO;
      r_err_count <= {ERR_W{1'b0}};
      r_err_addr  <= {ADDR_W{1'b0}};
      r_pass      <= 1'b0;
    end else begin
      r_err_count <= w_err_nxt;
      if (w_launch) begin
        r_pat      <= pat_sel_e'(pattern_sel);
        r_err_addr <= {ADDR_W{1'b0}};
        r_pass     <= 1'b0;
      end else begin
        r_pat <= r_pat;
        if (w_mis && (r_err_count == {ERR_W{1'b0}})) r_err_addr <= w_addr;
        else                                         r_err_addr <= r_err_addr;
        if (w_last_cmp) r_pass <= (w_err_nxt == {ERR_W{1'b0}});
        else            r_pass <= r_pass;
      end
    end
  end

  // Status flags registered from the next state so they line up with the phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == ST_WR) | (w_state_nxt == ST_RD) |
                (w_state_nxt == ST_WR_INV) | (w_state_nxt == ST_RD_INV);
      r_done <= (w_state_nxt == ST_DONE);
    end
  end

  assign ram_we    = w_wr_phase;
  assign ram_d     = w_wr_phase & w_exp;
  assign ram_a     = w_addr;
  assign ram_dpra  = w_addr;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_addr  = r_err_addr;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_dram_bist_ctrl.sv
// Self-checking bench for dram_bist_ctrl: fault-injecting RAM model, vector table and randomized runs.
`timescale 1ns/1ps
module tb_dram_bist_ctrl;

  localparam int AW    = 8;
  localparam int EW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int SAT   = (1 << EW) - 1;
  localparam int LAT   = 4 * DEPTH + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    pattern_sel = 2'd0;
  logic [AW-1:0] ram_a, ram_dpra, err_addr;
  logic          ram_d, ram_we, ram_spo, ram_dpo, busy, done, pass;
  logic [EW-1:0] err_count;

  bit mem  [DEPTH];
  bit sa0  [DEPTH];
  bit sa1  [DEPTH];
  bit flip [DEPTH];

  int n_checks = 0;
  int n_errors = 0;
  int we_bad   = 0;
  int addr_bad = 0;

  typedef struct {
    int sel;
    int kind;   // 0 none, 1 stuck-0, 2 stuck-1, 3 stuck-1 everywhere, 4 SPO-only flip
    int fa;
    int ecnt;
    int eaddr;
    int epass;
  } vec_t;

  vec_t tbl[8];

  always #5 clk = ~clk;

  dram_bist_ctrl #(.ADDR_W(AW), .ERR_W(EW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .pattern_sel (pattern_sel),
    .ram_a       (ram_a),
    .ram_d       (ram_d),
    .ram_we      (ram_we),
    .ram_dpra    (ram_dpra),
    .ram_spo     (ram_spo),
    .ram_dpo     (ram_dpo),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .err_addr    (err_addr),
    .err_count   (err_count)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_a] <= ram_d;
  end

  always_comb begin
    ram_dpo = mem[ram_dpra];
    if (sa0[ram_dpra]) ram_dpo = 1'b0;
    if (sa1[ram_dpra]) ram_dpo = 1'b1;
    ram_spo = mem[ram_a];
    if (sa0[ram_a]) ram_spo = 1'b0;
    if (sa1[ram_a]) ram_spo = 1'b1;
    ram_spo = ram_spo ^ flip[ram_a];
  end

  always @(negedge clk) begin
    if (ram_we && !busy) we_bad++;
    if (ram_a != ram_dpra) addr_bad++;
  end

  function automatic bit pat(input int sel, input int a);
    case (sel)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return bit'(a % 2);
      default: return bit'($countones(a) % 2);
    endcase
  endfunction

  function automatic void clear_faults();
    for (int i = 0; i < DEPTH; i++) begin
      sa0[i] = 1'b0; sa1[i] = 1'b0; flip[i] = 1'b0;
    end
  endfunction

  function automatic void apply_fault(input int kind, input int fa);
    case (kind)
      1: sa0[fa] = 1'b1;
      2: sa1[fa] = 1'b1;
      3: for (int i = 0; i < DEPTH; i++) sa1[i] = 1'b1;
      4: flip[fa] = 1'b1;
      default: ;
    endcase
  endfunction

  // Reference: each read phase sees the value just written, distorted by the read-side faults.
  function automatic void model(input int sel, output int cnt, output int first, output int ps);
    int n = 0;
    first = 0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int a = 0; a < DEPTH; a++) begin
        bit e, v, s, m;
        e = pat(sel, a) ^ (ph == 1);
        v = e;
        if (sa0[a]) v = 1'b0;
        if (sa1[a]) v = 1'b1;
        s = v ^ flip[a];
        m = (v != e);
`ifdef DRAM_BIST_SPO_CHECK_EN
        m = m | (s != e);
`else
        s = 1'b0;
`endif
        if (m) begin
          if (n == 0) first = a;
          n++;
        end
      end
    end
    cnt = (n > SAT) ? SAT : n;
    ps  = (n == 0) ? 1 : 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run(input int sel, input int toggle_at, input int rst_at,
                     output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    @(negedge clk);
    pattern_sel = sel[1:0];
    start = 1'b1;
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (busy) bcnt++;
      if (toggle_at > 0 && c == toggle_at) start = 1'b1;
      if (toggle_at > 0 && c == toggle_at + 2) begin
        start = 1'b0;
        pattern_sel = 2'd3;
      end
      if (c == rst_at) begin
        chk("rst.busy_before", int'(busy), 1);
        chk("rst.cnt_before", int'(err_count), 1);
        rst_n = 1'b0;
        #1;
        chk("rst.busy", int'(busy), 0);
        chk("rst.done", int'(done), 0);
        chk("rst.we", int'(ram_we), 0);
        chk("rst.cnt", int'(err_count), 0);
        chk("rst.addr", int'(err_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (done && bcnt > 0) begin
        lat = c;
        return;
      end
    end
  endtask

  task automatic check_run(input string tag, input int sel, input int ecnt, input int eaddr,
                           input int epass, input int lat, input int bcnt);
    int bad = 0;
    for (int a = 0; a < DEPTH; a++) begin
      if (mem[a] != (pat(sel, a) ^ 1'b1)) bad++;
    end
    chk($sformatf("%s.latency", tag), lat, LAT);
    chk($sformatf("%s.busy_cycles", tag), bcnt, 4 * DEPTH);
    chk($sformatf("%s.done", tag), int'(done), 1);
    chk($sformatf("%s.busy_low", tag), int'(busy), 0);
    chk($sformatf("%s.pass", tag), int'(pass), epass);
    chk($sformatf("%s.err_count", tag), int'(err_count), ecnt);
    chk($sformatf("%s.err_addr", tag), int'(err_addr), eaddr);
    chk($sformatf("%s.ram_content_bad", tag), bad, 0);
  endtask

  initial begin
    int lat, bcnt, ec, ea, ep, nf, sel;

    clear_faults();
    tbl[0] = '{2, 0, 0,    0,   0,    1};
    tbl[1] = '{1, 1, 'h5A, 1,   'h5A, 0};
    tbl[2] = '{0, 3, 0,    SAT, 0,    0};
    tbl[3] = '{3, 1, 'h03, 1,   'h03, 0};
    tbl[4] = '{2, 2, 'h20, 1,   'h20, 0};
    tbl[5] = '{2, 1, 'hFF, 1,   'hFF, 0};
    tbl[6] = '{3, 2, 'h00, 1,   'h00, 0};
`ifdef DRAM_BIST_SPO_CHECK_EN
    tbl[7] = '{0, 4, 'h10, 2,   'h10, 0};
`else
    tbl[7] = '{0, 4, 'h10, 0,   0,    1};
`endif

    repeat (3) @(negedge clk);
    chk("reset.busy", int'(busy), 0);
    chk("reset.done", int'(done), 0);
    chk("reset.pass", int'(pass), 0);
    chk("reset.err_count", int'(err_count), 0);
    chk("reset.err_addr", int'(err_addr), 0);
    chk("reset.we", int'(ram_we), 0);
    chk("reset.d", int'(ram_d), 0);
    chk("reset.a", int'(ram_a), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle.busy", int'(busy), 0);
    chk("idle.done", int'(done), 0);

    for (int i = 0; i < 8; i++) begin
      clear_faults();
      apply_fault(tbl[i].kind, tbl[i].fa);
      run(tbl[i].sel, 0, 0, lat, bcnt);
      check_run($sformatf("vec%0d", i), tbl[i].sel, tbl[i].ecnt, tbl[i].eaddr,
                tbl[i].epass, lat, bcnt);
    end

    for (int r = 0; r < 8; r++) begin
      clear_faults();
      nf = $urandom_range(0, 4);
      for (int f = 0; f < nf; f++) begin
        apply_fault($urandom_range(1, 2) + ($urandom_range(0, 2) == 0 ? 2 : 0) * ((f % 2) == 0 ? 1 : 0),
                    $urandom_range(0, DEPTH - 1));
      end
      sel = $urandom_range(0, 3);
      model(sel, ec, ea, ep);
      run(sel, 0, 0, lat, bcnt);
      check_run($sformatf("rand%0d", r), sel, ec, ea, ep, lat, bcnt);
    end

    clear_faults();
    apply_fault(2, 5);
    run(0, 0, 300, lat, bcnt);
    clear_faults();
    run(2, 0, 0, lat, bcnt);
    check_run("after_reset", 2, 0, 0, 1, lat, bcnt);

    run(0, 400, 0, lat, bcnt);
    check_run("toggle", 0, 0, 0, 1, lat, bcnt);
    repeat (5) @(negedge clk);
    chk("toggle.done_hold", int'(done), 1);
    chk("toggle.busy_hold", int'(busy), 0);

    chk("we_outside_write", we_bad, 0);
    chk("ram_a_vs_dpra", addr_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
